// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the five-stage MIPS pipeline.
// Holds register index width and hazard controller state encoding.
package cpu_types_pkg;

   localparam int unsigned REG_W = 5;

   typedef logic [REG_W-1:0] regbits_t;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      MEMWAIT = 2'd1,
      HALTED  = 2'd2
   } hazard_state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the hazard controller and the datapath.
// Mirrors the pipeline-latch interfaces: hc drives controls, dp drives status.
interface hazard_ctrl_if
   import cpu_types_pkg::*;
#(
   parameter int unsigned CNT_W = 16
);
   logic             ihit, dhit, dmem_req, ex_load, de_uses_rt, ex_pcsrc, mem_halt;
   regbits_t         ex_wsel, de_rs, de_rt;
   logic             fd_stall, fd_flush, de_stall, de_flush, em_stall, em_flush, mw_flush;
   logic             pc_en, halt;
   logic [CNT_W-1:0] stall_count;

   modport hc (
      input  ihit, dhit, dmem_req, ex_load, ex_wsel, de_rs, de_rt, de_uses_rt,
             ex_pcsrc, mem_halt,
      output fd_stall, fd_flush, de_stall, de_flush, em_stall, em_flush, mw_flush,
             pc_en, halt, stall_count
   );

   modport dp (
      output ihit, dhit, dmem_req, ex_load, ex_wsel, de_rs, de_rt, de_uses_rt,
             ex_pcsrc, mem_halt,
      input  fd_stall, fd_flush, de_stall, de_flush, em_stall, em_flush, mw_flush,
             pc_en, halt, stall_count
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/sequencing controller: latch stall/flush, PC enable,
// sticky halt and a saturating stall-cycle counter.
module hazard_ctrl
   import cpu_types_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             dmem_req,
   input  logic             ex_load,
   input  regbits_t         ex_wsel,
   input  regbits_t         de_rs,
   input  regbits_t         de_rt,
   input  logic             de_uses_rt,
   input  logic             ex_pcsrc,
   input  logic             mem_halt,
   output logic             fd_stall,
   output logic             fd_flush,
   output logic             de_stall,
   output logic             de_flush,
   output logic             em_stall,
   output logic             em_flush,
   output logic             mw_flush,
   output logic             pc_en,
   output logic             halt,
   output logic [CNT_W-1:0] stall_count
);

   hazard_state_t state;
   logic          luse, mstall, mstall_eff;

   always_comb begin
      luse = ex_load & (ex_wsel != '0)
           & ((ex_wsel == de_rs) | (de_uses_rt & (ex_wsel == de_rt)));
      mstall = dmem_req & ~dhit;
      // a completing access in MEMWAIT is treated as a hit, not a new miss
      mstall_eff = (state == RUN) ? mstall : 1'b0;

      fd_stall = 1'b0;
      fd_flush = 1'b0;
      de_stall = 1'b0;
      de_flush = 1'b0;
      em_stall = 1'b0;
      em_flush = 1'b0;
      mw_flush = 1'b0;
      pc_en    = 1'b0;

      if (state == HALTED) begin
         fd_stall = 1'b1;
         de_stall = 1'b1;
         em_stall = 1'b1;
         fd_flush = 1'b1;
         de_flush = 1'b1;
         mw_flush = 1'b1;
      end else if (state == MEMWAIT && !dhit) begin
         fd_stall = 1'b1;
         de_stall = 1'b1;
         em_stall = 1'b1;
      end else if (mem_halt) begin
         fd_stall = 1'b1;
         de_stall = 1'b1;
         em_stall = 1'b1;
         em_flush = 1'b1;
      end else if (mstall_eff) begin
         fd_stall = 1'b1;
         de_stall = 1'b1;
         em_stall = 1'b1;
      end else if (ex_pcsrc) begin
         fd_flush = 1'b1;
         de_flush = 1'b1;
         pc_en    = ihit;
      end else if (luse) begin
         fd_stall = 1'b1;
         de_flush = 1'b1;
      end else begin
         pc_en = ihit;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state       <= RUN;
         halt        <= 1'b0;
         stall_count <= '0;
      end else begin
         case (state)
            RUN: begin
               if (mem_halt) begin
                  state <= HALTED;
                  halt  <= 1'b1;
               end else if (mstall) begin
                  state <= MEMWAIT;
               end
            end
            MEMWAIT: if (dhit) state <= RUN;
            HALTED:  state <= HALTED;
            default: state <= RUN;
         endcase

         if (state != HALTED && !pc_en && stall_count != '1) begin
            stall_count <= stall_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed bench for hazard_ctrl against a behavioural model.
module tb_hazard_ctrl;
   import cpu_types_pkg::*;

   logic       CLK = 1'b0;
   logic       nRST;
   logic       ihit, dhit, dmem_req, ex_load, de_uses_rt, ex_pcsrc, mem_halt;
   regbits_t   ex_wsel, de_rs, de_rt;
   logic       fd_stall, fd_flush, de_stall, de_flush, em_stall, em_flush, mw_flush;
   logic       pc_en, halt;
   logic [15:0] stall_count;
   logic       s_fd_stall, s_fd_flush, s_de_stall, s_de_flush, s_em_stall, s_em_flush;
   logic       s_mw_flush, s_pc_en, s_halt;
   logic [1:0] s_stall_count;

   int n_cmp = 0;
   int n_bad = 0;

   // model state
   bit m_wait, m_halted;
   int m_cnt, m_cnt2;

   always #5 CLK = ~CLK;

   hazard_ctrl #(.CNT_W(16)) dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dmem_req(dmem_req),
      .ex_load(ex_load), .ex_wsel(ex_wsel), .de_rs(de_rs), .de_rt(de_rt),
      .de_uses_rt(de_uses_rt), .ex_pcsrc(ex_pcsrc), .mem_halt(mem_halt),
      .fd_stall(fd_stall), .fd_flush(fd_flush), .de_stall(de_stall), .de_flush(de_flush),
      .em_stall(em_stall), .em_flush(em_flush), .mw_flush(mw_flush), .pc_en(pc_en),
      .halt(halt), .stall_count(stall_count)
   );

   hazard_ctrl #(.CNT_W(2)) dut_sat (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dmem_req(dmem_req),
      .ex_load(ex_load), .ex_wsel(ex_wsel), .de_rs(de_rs), .de_rt(de_rt),
      .de_uses_rt(de_uses_rt), .ex_pcsrc(ex_pcsrc), .mem_halt(mem_halt),
      .fd_stall(s_fd_stall), .fd_flush(s_fd_flush), .de_stall(s_de_stall),
      .de_flush(s_de_flush), .em_stall(s_em_stall), .em_flush(s_em_flush),
      .mw_flush(s_mw_flush), .pc_en(s_pc_en), .halt(s_halt), .stall_count(s_stall_count)
   );

   task automatic check_val(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // {fd_stall, fd_flush, de_stall, de_flush, em_stall, em_flush, mw_flush, pc_en}
   function automatic logic [7:0] model_out();
      bit luse, miss;
      luse = ex_load && ex_wsel != 0 &&
             (ex_wsel == de_rs || (de_uses_rt && ex_wsel == de_rt));
      miss = dmem_req && !dhit;
      if (m_halted)               return 8'b1111_1010;
      if (m_wait && !dhit)        return 8'b1010_1000;
      if (mem_halt)               return 8'b1010_1100;
      if (!m_wait && miss)        return 8'b1010_1000;
      if (ex_pcsrc)               return {8'b0101_0000} | {7'b0, ihit};
      if (luse)                   return 8'b1001_0000;
      return {7'b0, ihit};
   endfunction

   function automatic logic [7:0] dut_out();
      return {fd_stall, fd_flush, de_stall, de_flush, em_stall, em_flush, mw_flush, pc_en};
   endfunction

   task automatic set_idle();
      ihit = 1'b1; dhit = 1'b0; dmem_req = 1'b0; ex_load = 1'b0; de_uses_rt = 1'b0;
      ex_pcsrc = 1'b0; mem_halt = 1'b0; ex_wsel = '0; de_rs = '0; de_rt = '0;
   endtask

   // Called just after a negedge with inputs set; returns at the next negedge.
   task automatic step(input string tag);
      logic [7:0] exp;
      #1;
      exp = model_out();
      check_val({tag, ".ctl"}, int'(dut_out()), int'(exp));
      check_val({tag, ".halt"}, int'(halt), int'(m_halted));
      check_val({tag, ".cnt"}, int'(stall_count), m_cnt);
      check_val({tag, ".cnt2"}, int'(s_stall_count), m_cnt2);
      if (!m_halted && !exp[0]) begin
         if (m_cnt < 65535) m_cnt++;
         if (m_cnt2 < 3) m_cnt2++;
      end
      if (!m_halted) begin
         if (m_wait) begin
            if (dhit) m_wait = 0;
         end else if (mem_halt) begin
            m_halted = 1;
         end else if (dmem_req && !dhit) begin
            m_wait = 1;
         end
      end
      @(negedge CLK);
   endtask

   // Asserts reset between clock edges and checks its effect before any edge.
   task automatic apply_reset(input string tag);
      set_idle();
      nRST = 1'b0;
      m_wait = 0; m_halted = 0; m_cnt = 0; m_cnt2 = 0;
      #1;
      check_val({tag, ".ctl"}, int'(dut_out()), int'(model_out()));
      check_val({tag, ".halt"}, int'(halt), 0);
      check_val({tag, ".cnt"}, int'(stall_count), 0);
      check_val({tag, ".cnt2"}, int'(s_stall_count), 0);
      @(negedge CLK);
      nRST = 1'b1;
   endtask

   initial begin
      int halted_cycles;
      set_idle();
      nRST = 1'b0;
      @(negedge CLK);
      apply_reset("rst0");

      // load-use: one bubble then the hazard clears
      ex_load = 1; ex_wsel = 5'd5; de_rs = 5'd5;
      step("luse");
      set_idle();
      step("luse_after");
      check_val("luse_cnt", int'(stall_count), 1);

      // $zero destination never stalls
      ex_load = 1; ex_wsel = 5'd0; de_rs = 5'd0;
      step("zero");
      set_idle();

      // data miss for 3 cycles, then hit
      dmem_req = 1;
      for (int i = 0; i < 3; i++) step("miss");
      dhit = 1;
      step("miss_hit");
      set_idle();
      step("after_miss");
      check_val("miss_cnt", int'(stall_count), 4);

      // branch alone and branch over a load-use match
      ex_pcsrc = 1;
      step("br");
      ex_load = 1; ex_wsel = 5'd7; de_rs = 5'd7;
      step("br_luse");
      set_idle();

      // reset in the middle of a miss wait
      dmem_req = 1;
      step("miss2");
      step("miss3");
      apply_reset("rst_wait");

      // halt: flush em now, halt sticky after
      mem_halt = 1;
      step("halt_req");
      set_idle();
      for (int i = 0; i < 4; i++) step("halted");
      apply_reset("rst_halt");

      // randomized run
      halted_cycles = 0;
      for (int i = 0; i < 3000; i++) begin
         ihit       = ($urandom_range(0, 3) != 0);
         dhit       = $urandom_range(0, 1);
         dmem_req   = ($urandom_range(0, 3) == 0);
         ex_pcsrc   = ($urandom_range(0, 4) == 0);
         ex_load    = ($urandom_range(0, 2) == 0);
         de_uses_rt = $urandom_range(0, 1);
         ex_wsel    = regbits_t'($urandom_range(0, 3));
         de_rs      = regbits_t'($urandom_range(0, 3));
         de_rt      = regbits_t'($urandom_range(0, 3));
         mem_halt   = !m_wait && ($urandom_range(0, 149) == 0);
         step("rnd");
         if (m_halted) halted_cycles++;
         if (halted_cycles > 5) begin
            halted_cycles = 0;
            apply_reset("rnd_rst");
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the five-stage MIPS datapath. It generates the stall and flush controls for the fetch/decode, decode/execute, execute/memory and memory/writeback pipeline latches, plus the PC enable. Each latch holds on `stall` and bubbles on `flush`. The block tracks outstanding data-memory accesses, load-use hazards, taken control transfers and halt in a small FSM, and keeps a saturating stall-cycle counter for performance debug.

## Interface
- CNT_W, 16, width of stall-cycle counter
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- ihit  in  1  instruction fetch completed this cycle
- dhit  in  1  data access completed this cycle
- dmem_req  in  1  execute/memory latch holds a load or store (dREN or dWEN)
- ex_load  in  1  decode/execute latch holds a load (dREN)
- ex_wsel  in  5  destination register of the instruction in execute
- de_rs  in  5  rs field of the instruction in decode
- de_rt  in  5  rt field of the instruction in decode
- de_uses_rt  in  1  decode instruction reads rt (R-type, beq/bne, sw)
- ex_pcsrc  in  1  taken branch, j, jal or jr resolved in execute
- mem_halt  in  1  halt instruction has reached the memory stage
- fd_stall, fd_flush  out  1 each  fetch/decode latch controls
- de_stall, de_flush  out  1 each  decode/execute latch controls
- em_stall, em_flush  out  1 each  execute/memory latch controls
- mw_flush  out  1  memory/writeback latch flush
- pc_en  out  1  PC register update enable
- halt  out  1  registered, sticky processor halt
- stall_count  out  CNT_W  cycles with pc_en low since reset

## Operation
- FSM states: RUN, MEMWAIT, HALTED. Reset state is RUN.
- Hazard terms:
  - `luse = ex_load & (ex_wsel != 0) & (ex_wsel == de_rs | (de_uses_rt & ex_wsel == de_rt))`
  - `mstall = dmem_req & ~dhit`
- RUN output priority, highest first:
  1. mem_halt: all stalls 1, pc_en 0, em_flush 1, mw_flush 0.
  2. mstall: fd_stall, de_stall and em_stall 1; pc_en 0.
  3. ex_pcsrc: fd_flush 1, de_flush 1, pc_en = ihit.
  4. luse: fd_stall 1, de_flush 1 (inserts one bubble), pc_en 0.
  5. Otherwise all stalls and flushes 0, pc_en = ihit.
- RUN transitions:
  - mem_halt goes to HALTED.
  - Otherwise mstall goes to MEMWAIT.
  - Otherwise stay in RUN.
- MEMWAIT:
  - While dhit is 0: fd_stall, de_stall and em_stall 1; pc_en 0.
  - On dhit: outputs follow the RUN rules with mstall forced to 0, and the next state is RUN.
  - mem_halt cannot occur in MEMWAIT, because a halt carries no memory request.
- HALTED:
  - All stalls 1, pc_en 0, mw_flush 1, halt 1.
  - Leaves only on reset.
- ex_pcsrc and ex_load describe the same execute-stage instruction and are mutually exclusive. If both are asserted, ex_pcsrc wins.
- Flush has precedence over stall inside each latch. The controller never asserts both on the same latch except fd/de in HALTED.
- stall_count increments by 1 in every non-HALTED cycle with pc_en 0. It saturates at 2^CNT_W-1 and does not wrap. It is frozen in HALTED.

## Timing
- All stall, flush and pc_en outputs are combinational from the current state and inputs, with no added latency. They act on the same CLK edge as the latches.
- halt is registered: it asserts the cycle after mem_halt is sampled in RUN.
- A load-use hazard costs exactly 1 bubble. The cycle after luse, ex_load is 0 because the bubble is in execute, so luse drops.
- A taken control transfer costs 2 squashed instructions, the ones in fetch/decode and decode/execute.
- Reset values: state RUN, halt 0, stall_count 0. Combinational outputs then follow the RUN rules for the current inputs.
- Async reset mid-MEMWAIT or mid-HALTED returns to RUN immediately.

## Structure
- Add `hazard_state_t` (RUN, MEMWAIT, HALTED) to `cpu_types_pkg`. Register index width uses the existing `regbits_t`.
- Use a single module with no sub-modules. Hazard detection is a combinational block; the FSM and counter share one always_ff.
- Interface bundle `hazard_ctrl_if` with modports `hc` (this block) and `dp` (datapath), consistent with the pipeline-latch interfaces.

## Test plan
- Load-use: ex_load=1, ex_wsel=5, de_rs=5, ihit=1 → fd_stall=1, de_flush=1, pc_en=0 for exactly 1 cycle; stall_count=1.
- $zero exemption: ex_load=1, ex_wsel=0, de_rs=0 → no stall, pc_en=1.
- Data miss: dmem_req=1, dhit=0 for 3 cycles, then dhit=1 → fd/de/em_stall high for 3 cycles (state MEMWAIT); 4th cycle stalls low, state RUN; stall_count=3.
- Branch: ex_pcsrc=1, ihit=1 → fd_flush=1, de_flush=1, pc_en=1. Same cycle with ex_load=1 and a luse match → flushes win, fd_stall=0.
- Halt: mem_halt=1 → em_flush=1 that cycle; halt=1 next cycle and stays 1; stall_count frozen; pc_en 0.
- Async reset: nRST low mid-MEMWAIT → state RUN, halt 0, stall_count 0 with no clock edge; saturation with CNT_W=2 holds at 3.
